// File: rtl/pipe_check_pkg.sv
// Shared types and field widths for the pipeline store checker.
package pipe_check_pkg;

  localparam int unsigned STATE_W     = 2;
  localparam int unsigned FAIL_CODE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  typedef enum logic [FAIL_CODE_W-1:0] {
    FC_NONE          = 2'd0,
    FC_UNEXP_ADDR    = 2'd1,
    FC_DATA_MISMATCH = 2'd2,
    FC_TIMEOUT       = 2'd3
  } fail_code_t;

  // Index width that stays legal for a single-entry table.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_store_checker_if.sv
// Configuration, store tap and status bundle of the store checker.
interface pipe_store_checker_if #(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_ADDR_WIDTH = 32,
  parameter int unsigned P_NUM_EXP    = 4,
  parameter int unsigned P_CNT_WIDTH  = 16
);
  localparam int unsigned IDX_W = pipe_check_pkg::idx_width(P_NUM_EXP);
  localparam int unsigned CNT_W = $clog2(P_NUM_EXP + 1);

  logic                    i_exp_we;
  logic [IDX_W-1:0]        i_exp_idx;
  logic [P_ADDR_WIDTH-1:0] i_exp_addr;
  logic [P_DATA_WIDTH-1:0] i_exp_data;
  logic [CNT_W-1:0]        i_exp_count;
  logic                    i_unordered;
  logic                    i_ign_en;
  logic [P_ADDR_WIDTH-1:0] i_ign_addr;
  logic                    i_start;
  logic                    i_mem_write;
  logic [P_ADDR_WIDTH-1:0] i_mem_addr;
  logic [P_DATA_WIDTH-1:0] i_mem_data;

  logic                    o_busy;
  logic                    o_done;
  logic                    o_pass;
  logic [pipe_check_pkg::FAIL_CODE_W-1:0] o_fail_code;
  logic [P_ADDR_WIDTH-1:0] o_fail_addr;
  logic [P_DATA_WIDTH-1:0] o_fail_data;
  logic [CNT_W-1:0]        o_match_count;
  logic [P_CNT_WIDTH-1:0]  o_ign_count;
  logic [P_CNT_WIDTH-1:0]  o_cycle_count;

  modport master (
    output i_exp_we, i_exp_idx, i_exp_addr, i_exp_data, i_exp_count,
           i_unordered, i_ign_en, i_ign_addr, i_start,
           i_mem_write, i_mem_addr, i_mem_data,
    input  o_busy, o_done, o_pass, o_fail_code, o_fail_addr, o_fail_data,
           o_match_count, o_ign_count, o_cycle_count
  );

  modport slave (
    input  i_exp_we, i_exp_idx, i_exp_addr, i_exp_data, i_exp_count,
           i_unordered, i_ign_en, i_ign_addr, i_start,
           i_mem_write, i_mem_addr, i_mem_data,
    output o_busy, o_done, o_pass, o_fail_code, o_fail_addr, o_fail_data,
           o_match_count, o_ign_count, o_cycle_count
  );

endinterface

// File: rtl/pipe_check_table.sv
// Expected-store register file with matched bitmap and per-entry compare vectors.
module pipe_check_table #(
  parameter  int unsigned P_DATA_WIDTH = 32,
  parameter  int unsigned P_ADDR_WIDTH = 32,
  parameter  int unsigned P_NUM_EXP    = 4,
  localparam int unsigned IDX_W        = pipe_check_pkg::idx_width(P_NUM_EXP)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_we,
  input  logic [IDX_W-1:0]        i_widx,
  input  logic [P_ADDR_WIDTH-1:0] i_waddr,
  input  logic [P_DATA_WIDTH-1:0] i_wdata,
  input  logic                    i_clr_match,
  input  logic [P_NUM_EXP-1:0]    i_set_match,
  input  logic [P_ADDR_WIDTH-1:0] i_addr,
  input  logic [P_DATA_WIDTH-1:0] i_data,
  output logic [P_NUM_EXP-1:0]    o_addr_hit_c,
  output logic [P_NUM_EXP-1:0]    o_data_eq_c,
  output logic [P_NUM_EXP-1:0]    o_matched
);

  logic [P_NUM_EXP-1:0][P_ADDR_WIDTH-1:0] addr_q;
  logic [P_NUM_EXP-1:0][P_DATA_WIDTH-1:0] data_q;
  logic [P_NUM_EXP-1:0]                   matched_q;

  // Entry storage and matched bitmap; a start clears the bitmap only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q    <= '0;
      data_q    <= '0;
      matched_q <= '0;
    end else begin
      if (i_we && (32'(i_widx) < P_NUM_EXP)) begin
        addr_q[i_widx] <= i_waddr;
        data_q[i_widx] <= i_wdata;
      end
      if (i_clr_match) begin
        matched_q <= '0;
      end else begin
        matched_q <= matched_q | i_set_match;
      end
    end
  end

  // Raw per-entry comparison against the observed store.
  always_comb begin
    o_addr_hit_c = '0;
    o_data_eq_c  = '0;
    for (int i = 0; i < int'(P_NUM_EXP); i++) begin
      o_addr_hit_c[i] = (addr_q[i] == i_addr);
      o_data_eq_c[i]  = (data_q[i] == i_data);
    end
  end

  assign o_matched = matched_q;

endmodule

// File: rtl/pipe_store_checker.sv
// MEM-stage store checker: FSM, counters and entry selection around the table.
module pipe_store_checker #(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_ADDR_WIDTH = 32,
  parameter int unsigned P_NUM_EXP    = 4,
  parameter int unsigned P_CNT_WIDTH  = 16,
  parameter int unsigned P_TIMEOUT    = 5000
) (
  input logic                i_clk,
  input logic                i_rst,
  pipe_store_checker_if.slave bus
);
  import pipe_check_pkg::*;

  localparam int unsigned IDX_W = idx_width(P_NUM_EXP);
  localparam int unsigned CNT_W = $clog2(P_NUM_EXP + 1);
  localparam logic [P_CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [P_CNT_WIDTH-1:0] TIMEOUT_V = P_CNT_WIDTH'(P_TIMEOUT);
  localparam logic [CNT_W-1:0]       NUM_EXP_V = CNT_W'(P_NUM_EXP);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_lat_q, cnt_lat_d;
  logic                    unord_q, unord_d;
  logic                    ign_en_q, ign_en_d;
  logic [P_ADDR_WIDTH-1:0] ign_addr_q, ign_addr_d;
  logic [CNT_W-1:0]        match_cnt_q, match_cnt_d;
  logic [P_CNT_WIDTH-1:0]  ign_cnt_q, ign_cnt_d;
  logic [P_CNT_WIDTH-1:0]  cyc_q, cyc_d;
  fail_code_t              fail_code_q, fail_code_d;
  logic [P_ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [P_DATA_WIDTH-1:0] fail_data_q, fail_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;

  logic                    clr_match;
  logic [P_NUM_EXP-1:0]    set_match;
  logic [P_NUM_EXP-1:0]    addr_hit;
  logic [P_NUM_EXP-1:0]    data_eq;
  logic [P_NUM_EXP-1:0]    matched;

  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        uo_sel;
  logic                    uo_found;
  logic [IDX_W-1:0]        sel_idx;
  logic                    hit_sel;
  logic                    eq_sel;
  logic                    is_ign;
  logic                    ev;
  logic                    ev_match;
  logic                    ev_ign;
  fail_code_t              ev_code;
  logic [P_CNT_WIDTH-1:0]  cyc_sat;
  logic [CNT_W-1:0]        match_after;

  pipe_check_table #(
    .P_DATA_WIDTH (P_DATA_WIDTH),
    .P_ADDR_WIDTH (P_ADDR_WIDTH),
    .P_NUM_EXP    (P_NUM_EXP)
  ) u_table (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_we         (bus.i_exp_we && (state_q != ST_RUN)),
    .i_widx       (bus.i_exp_idx),
    .i_waddr      (bus.i_exp_addr),
    .i_wdata      (bus.i_exp_data),
    .i_clr_match  (clr_match),
    .i_set_match  (set_match),
    .i_addr       (bus.i_mem_addr),
    .i_data       (bus.i_mem_data),
    .o_addr_hit_c (addr_hit),
    .o_data_eq_c  (data_eq),
    .o_matched    (matched)
  );

  // Classify the current store: match, ignore, or failure code.
  always_comb begin
    ptr      = IDX_W'(match_cnt_q);
    uo_found = 1'b0;
    uo_sel   = '0;
    // Descending scan so the lowest-index unmatched in-use hit wins.
    for (int i = int'(P_NUM_EXP) - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < cnt_lat_q) && !matched[i] && addr_hit[i]) begin
        uo_found = 1'b1;
        uo_sel   = IDX_W'(i);
      end
    end
    sel_idx  = unord_q ? uo_sel : ptr;
    hit_sel  = unord_q ? uo_found : addr_hit[ptr];
    eq_sel   = data_eq[sel_idx];
    is_ign   = ign_en_q && (bus.i_mem_addr == ign_addr_q);
    ev       = (state_q == ST_RUN) && bus.i_mem_write && (match_cnt_q < cnt_lat_q);
    ev_match = ev && hit_sel && eq_sel;
    ev_ign   = ev && !hit_sel && is_ign;
    ev_code  = FC_NONE;
    if (ev && hit_sel && !eq_sel) begin
      ev_code = FC_DATA_MISMATCH;
    end else if (ev && !hit_sel && !is_ign) begin
      ev_code = FC_UNEXP_ADDR;
    end
    cyc_sat     = (cyc_q != CNT_MAX) ? cyc_q + P_CNT_WIDTH'(1) : cyc_q;
    match_after = match_cnt_q + CNT_W'(ev_match);
  end

  // Next-state and next-value logic.
  always_comb begin
    state_d     = state_q;
    cnt_lat_d   = cnt_lat_q;
    unord_d     = unord_q;
    ign_en_d    = ign_en_q;
    ign_addr_d  = ign_addr_q;
    match_cnt_d = match_cnt_q;
    ign_cnt_d   = ign_cnt_q;
    cyc_d       = cyc_q;
    fail_code_d = fail_code_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    clr_match   = 1'b0;
    set_match   = '0;
    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (bus.i_start) begin
          state_d     = ST_RUN;
          cnt_lat_d   = (bus.i_exp_count > NUM_EXP_V) ? NUM_EXP_V : bus.i_exp_count;
          unord_d     = bus.i_unordered;
          ign_en_d    = bus.i_ign_en;
          ign_addr_d  = bus.i_ign_addr;
          match_cnt_d = '0;
          ign_cnt_d   = '0;
          cyc_d       = '0;
          fail_code_d = FC_NONE;
          fail_addr_d = '0;
          fail_data_d = '0;
          clr_match   = 1'b1;
        end
      end
      ST_RUN: begin
        cyc_d = cyc_sat;
        if (ev_match) begin
          set_match[sel_idx] = 1'b1;
          match_cnt_d        = match_after;
        end
        if (ev_ign && (ign_cnt_q != CNT_MAX)) begin
          ign_cnt_d = ign_cnt_q + P_CNT_WIDTH'(1);
        end
        // Pass outranks a coincident timeout; a store error outranks timeout.
        if (match_after == cnt_lat_q) begin
          state_d = ST_PASS;
        end else if (ev_code != FC_NONE) begin
          state_d     = ST_FAIL;
          fail_code_d = ev_code;
          fail_addr_d = bus.i_mem_addr;
          fail_data_d = bus.i_mem_data;
        end else if (cyc_sat >= TIMEOUT_V) begin
          state_d     = ST_FAIL;
          fail_code_d = FC_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_PASS) || (state_d == ST_FAIL);
    pass_d = (state_d == ST_PASS);
  end

  // State, configuration, counters and registered status.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_lat_q   <= '0;
      unord_q     <= 1'b0;
      ign_en_q    <= 1'b0;
      ign_addr_q  <= '0;
      match_cnt_q <= '0;
      ign_cnt_q   <= '0;
      cyc_q       <= '0;
      fail_code_q <= FC_NONE;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_lat_q   <= cnt_lat_d;
      unord_q     <= unord_d;
      ign_en_q    <= ign_en_d;
      ign_addr_q  <= ign_addr_d;
      match_cnt_q <= match_cnt_d;
      ign_cnt_q   <= ign_cnt_d;
      cyc_q       <= cyc_d;
      fail_code_q <= fail_code_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_pass        = pass_q;
  assign bus.o_fail_code   = fail_code_q;
  assign bus.o_fail_addr   = fail_addr_q;
  assign bus.o_fail_data   = fail_data_q;
  assign bus.o_match_count = match_cnt_q;
  assign bus.o_ign_count   = ign_cnt_q;
  assign bus.o_cycle_count = cyc_q;

endmodule

// File: tb/tb_pipe_store_checker.sv
// Bench for pipe_store_checker: directed scenarios plus random runs against a queue-based model.
module tb_pipe_store_checker;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NE = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned TO = 20;
  localparam int unsigned KW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_store_checker_if #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_NUM_EXP(NE), .P_CNT_WIDTH(CW)) bus ();

  pipe_store_checker #(
    .P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_NUM_EXP(NE), .P_CNT_WIDTH(CW), .P_TIMEOUT(TO)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic [AW-1:0] m_tab_a [NE];
  logic [DW-1:0] m_tab_d [NE];
  ent_t          m_rem [$];
  bit            m_run, m_done, m_pass, m_unord, m_ign_en;
  int            m_code, m_cnt, m_ign, m_cyc;
  logic [AW-1:0] m_faddr, m_ign_addr;
  logic [DW-1:0] m_fdata;

  always @(posedge clk or posedge rst) begin : model
    int hit;
    bit err;
    if (rst) begin
      foreach (m_tab_a[i]) begin m_tab_a[i] = '0; m_tab_d[i] = '0; end
      m_rem.delete();
      m_run = 0; m_done = 0; m_pass = 0; m_unord = 0; m_ign_en = 0;
      m_code = 0; m_cnt = 0; m_ign = 0; m_cyc = 0;
      m_faddr = '0; m_fdata = '0; m_ign_addr = '0;
    end else if (!m_run) begin
      if (bus.i_exp_we) begin
        m_tab_a[bus.i_exp_idx] = bus.i_exp_addr;
        m_tab_d[bus.i_exp_idx] = bus.i_exp_data;
      end
      if (bus.i_start) begin
        m_cnt = (int'(bus.i_exp_count) > NE) ? NE : int'(bus.i_exp_count);
        m_unord = bus.i_unordered; m_ign_en = bus.i_ign_en; m_ign_addr = bus.i_ign_addr;
        m_rem.delete();
        for (int i = 0; i < m_cnt; i++) m_rem.push_back('{a: m_tab_a[i], d: m_tab_d[i]});
        m_run = 1; m_done = 0; m_pass = 0;
        m_code = 0; m_faddr = '0; m_fdata = '0; m_ign = 0; m_cyc = 0;
      end
    end else begin
      hit = -1;
      err = 0;
      if (m_cyc < 65535) m_cyc++;
      if (m_rem.size() > 0 && bus.i_mem_write) begin
        if (!m_unord) begin
          if (m_rem[0].a == bus.i_mem_addr) hit = 0;
        end else begin
          foreach (m_rem[i]) if (hit < 0 && m_rem[i].a == bus.i_mem_addr) hit = i;
        end
        if (hit >= 0) begin
          if (m_rem[hit].d == bus.i_mem_data) m_rem.delete(hit);
          else begin err = 1; m_code = 2; end
        end else if (m_ign_en && bus.i_mem_addr == m_ign_addr) begin
          if (m_ign < 65535) m_ign++;
        end else begin
          err = 1; m_code = 1;
        end
        if (err) begin m_faddr = bus.i_mem_addr; m_fdata = bus.i_mem_data; end
      end
      if (m_rem.size() == 0) begin
        m_run = 0; m_done = 1; m_pass = 1;
      end else if (err) begin
        m_run = 0; m_done = 1;
      end else if (m_cyc >= int'(TO)) begin
        m_run = 0; m_done = 1; m_code = 3;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",   64'(bus.o_busy),        64'(m_run));
      chk("done",   64'(bus.o_done),        64'(m_done));
      chk("pass",   64'(bus.o_pass),        64'(m_pass));
      chk("code",   64'(bus.o_fail_code),   64'(m_code));
      chk("faddr",  64'(bus.o_fail_addr),   64'(m_faddr));
      chk("fdata",  64'(bus.o_fail_data),   64'(m_fdata));
      chk("match",  64'(bus.o_match_count), 64'(m_cnt - m_rem.size()));
      chk("ign",    64'(bus.o_ign_count),   64'(m_ign));
      chk("cycles", 64'(bus.o_cycle_count), 64'(m_cyc));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.i_exp_we = 1; bus.i_exp_idx = 2'(idx); bus.i_exp_addr = a; bus.i_exp_data = d;
    tick();
    bus.i_exp_we = 0;
  endtask

  task automatic start(input int cnt, input bit unord, input bit ign_en, input logic [AW-1:0] ign_a,
                       input bit co = 0, input logic [AW-1:0] a = '0, input logic [DW-1:0] d = '0);
    bus.i_exp_count = KW'(cnt); bus.i_unordered = unord;
    bus.i_ign_en = ign_en; bus.i_ign_addr = ign_a;
    bus.i_start = 1; bus.i_mem_write = co; bus.i_mem_addr = a; bus.i_mem_data = d;
    tick();
    bus.i_start = 0; bus.i_mem_write = 0;
  endtask

  task automatic st(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.i_mem_write = 1; bus.i_mem_addr = a; bus.i_mem_data = d;
    tick();
    bus.i_mem_write = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.i_exp_we = 0; bus.i_exp_idx = '0; bus.i_exp_addr = '0; bus.i_exp_data = '0;
    bus.i_exp_count = '0; bus.i_unordered = 0; bus.i_ign_en = 0; bus.i_ign_addr = '0;
    bus.i_start = 0; bus.i_mem_write = 0; bus.i_mem_addr = '0; bus.i_mem_data = '0;
    #1 rst = 1;
    #1 chk_en = 1;
    chk("reset_busy", 64'(bus.o_busy), 64'd0);
    chk("reset_cycles", 64'(bus.o_cycle_count), 64'd0);
    tick(2);
    rst = 0;
    tick();

    // Ordered pass
    wr(0, 96, 7); wr(1, 100, 25);
    start(2, 0, 0, 0);
    st(96, 7); st(100, 25);
    chk("t1_pass", 64'(bus.o_pass), 64'd1);
    chk("t1_match", 64'(bus.o_match_count), 64'd2);
    chk("t1_code", 64'(bus.o_fail_code), 64'd0);

    // Ignore and data mismatch
    wr(0, 100, 25);
    start(1, 0, 1, 96);
    st(96, 3); st(96, 9); st(100, 24);
    chk("t2_done", 64'(bus.o_done), 64'd1);
    chk("t2_code", 64'(bus.o_fail_code), 64'd2);
    chk("t2_faddr", 64'(bus.o_fail_addr), 64'd100);
    chk("t2_fdata", 64'(bus.o_fail_data), 64'd24);
    chk("t2_ign", 64'(bus.o_ign_count), 64'd2);

    // Unordered pass, then the same stores in ordered mode
    wr(0, 4, 1); wr(1, 8, 2); wr(2, 12, 3);
    start(3, 1, 0, 0);
    st(12, 3); st(4, 1); st(8, 2);
    chk("t3_pass", 64'(bus.o_pass), 64'd1);
    chk("t3_match", 64'(bus.o_match_count), 64'd3);
    start(3, 0, 0, 0);
    st(12, 3);
    chk("t3o_code", 64'(bus.o_fail_code), 64'd1);
    chk("t3o_faddr", 64'(bus.o_fail_addr), 64'd12);

    // Timeout, then a successful rerun
    wr(0, 96, 7);
    start(1, 0, 0, 0);
    tick(25);
    chk("t4_code", 64'(bus.o_fail_code), 64'd3);
    chk("t4_cycles", 64'(bus.o_cycle_count), 64'd20);
    chk("t4_faddr", 64'(bus.o_fail_addr), 64'd0);
    chk("t4_fdata", 64'(bus.o_fail_data), 64'd0);
    start(1, 0, 0, 0);
    st(96, 7);
    chk("t4r_pass", 64'(bus.o_pass), 64'd1);
    chk("t4r_cycles", 64'(bus.o_cycle_count), 64'd1);

    // Count of zero passes one cycle after start
    start(0, 0, 0, 0);
    chk("t5_busy", 64'(bus.o_busy), 64'd1);
    tick();
    chk("t5_pass", 64'(bus.o_pass), 64'd1);
    chk("t5_cycles", 64'(bus.o_cycle_count), 64'd1);

    // Store coincident with start is not evaluated
    start(1, 0, 0, 0, 1, 96, 7);
    chk("t6_busy", 64'(bus.o_busy), 64'd1);
    chk("t6_match", 64'(bus.o_match_count), 64'd0);
    st(96, 7);
    chk("t6_pass", 64'(bus.o_pass), 64'd1);

    // Final match on the timeout edge
    start(1, 0, 0, 0);
    tick(19);
    chk("t7_busy", 64'(bus.o_busy), 64'd1);
    st(96, 7);
    chk("t7_pass", 64'(bus.o_pass), 64'd1);
    chk("t7_cycles", 64'(bus.o_cycle_count), 64'd20);
    chk("t7_code", 64'(bus.o_fail_code), 64'd0);

    // Asynchronous reset mid-run
    start(1, 0, 1, 0);
    st(0, 0);
    tick(2);
    rst = 1;
    #2;
    chk("t8_busy", 64'(bus.o_busy), 64'd0);
    chk("t8_cycles", 64'(bus.o_cycle_count), 64'd0);
    chk("t8_ign", 64'(bus.o_ign_count), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    tick();

    // Randomized runs
    for (int run = 0; run < 60; run++) begin
      for (int k = 0; k < int'($urandom_range(1, 4)); k++)
        wr(int'($urandom_range(0, NE - 1)), AW'(4 * $urandom_range(0, 4)), DW'($urandom_range(0, 3)));
      start(int'($urandom_range(0, 5)), 1'($urandom), 1'($urandom), AW'(4 * $urandom_range(0, 4)),
            1'($urandom), AW'(4 * $urandom_range(0, 4)), DW'($urandom_range(0, 3)));
      for (int c = 0; c < 23; c++) begin
        int r;
        int e;
        r = int'($urandom_range(0, 7));
        e = int'($urandom_range(0, NE - 1));
        bus.i_mem_write = ($urandom_range(0, 2) != 0);
        if (r < 4) begin
          bus.i_mem_addr = m_tab_a[e]; bus.i_mem_data = m_tab_d[e];
        end else if (r == 4) begin
          bus.i_mem_addr = m_tab_a[e]; bus.i_mem_data = m_tab_d[e] ^ DW'(1);
        end else begin
          bus.i_mem_addr = AW'(4 * $urandom_range(0, 4)); bus.i_mem_data = DW'($urandom_range(0, 3));
        end
        bus.i_exp_we = ($urandom_range(0, 7) == 0);
        bus.i_exp_idx = 2'($urandom_range(0, NE - 1));
        bus.i_exp_addr = AW'(4 * $urandom_range(0, 4));
        bus.i_exp_data = DW'($urandom_range(0, 3));
        tick();
        bus.i_mem_write = 0;
        bus.i_exp_we = 0;
      end
    end

    tick();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
